// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream
//
// Routes one valid/ready input stream to one of four output lanes. The lane
// is chosen per transfer by in_sel. Each lane has a single-entry register
// slot, so a stalled consumer only blocks traffic aimed at its own lane.
//
// Ports
//   clk                 rising-edge clock for all state
//   rst_n               asynchronous active-low reset; clears every slot
//   in_valid/in_ready   input handshake; in_ready reflects the selected lane
//   in_data [WIDTH]     input payload
//   in_sel  [2]         destination lane 0..3, qualified by in_valid
//   out_valid[4]        bit i set while lane i holds data
//   out_ready[4]        bit i: consumer i takes lane i data this cycle
//   out_data0..3        per-lane payload, held while the lane is stalled
//   occupancy[3]        registered count of full slots, 0..4
module demux_1_4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [2:0]       occupancy
);

  // Number of set bits in a lane mask; result never exceeds 4.
  function automatic logic [2:0] popcount4(input logic [3:0] mask);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, mask[i]};
    end
    return cnt;
  endfunction

  logic [3:0]       valid_r;
  logic [WIDTH-1:0] data_r [4];
  logic [2:0]       occ_r;

  logic             in_ready_s;
  logic             accept_s;
  logic [3:0]       wr_s;
  logic [3:0]       drain_s;
  logic [3:0]       valid_next_s;
  logic [2:0]       occ_next_s;

  // Handshake decode and next-state for the per-lane FULL/EMPTY bits.
  always_comb begin
    in_ready_s   = 1'b0;
    accept_s     = 1'b0;
    wr_s         = 4'b0000;
    drain_s      = 4'b0000;
    valid_next_s = valid_r;
    occ_next_s   = occ_r;

    // A full lane can still accept when its consumer empties it this cycle.
    in_ready_s = ~valid_r[in_sel] | out_ready[in_sel];
    accept_s   = in_valid & in_ready_s;

    if (accept_s) begin
      wr_s = 4'b0001 << in_sel;
    end else begin
      wr_s = 4'b0000;
    end

    // Ready on an empty lane is ignored. Drain includes a lane that is also
    // written this cycle: the write re-sets the valid bit below, and the
    // count nets to zero for that lane (+1 accept, -1 drain).
    drain_s      = valid_r & out_ready;
    valid_next_s = (valid_r & ~drain_s) | wr_s;
    occ_next_s   = occ_r + {2'b00, accept_s} - popcount4(drain_s);
  end

  // Lane valid bits and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 4'b0000;
      occ_r   <= 3'd0;
    end else begin
      valid_r <= valid_next_s;
      occ_r   <= occ_next_s;
    end
  end

  // Lane payload slots; only a write changes a slot, so stalled data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_s[i]) begin
          data_r[i] <= in_data;
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r;
  assign occupancy = occ_r;
  assign out_data0 = data_r[0];
  assign out_data1 = data_r[1];
  assign out_data2 = data_r[2];
  assign out_data3 = data_r[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed testbench for demux_1_4_stream with hand-computed expectations.
module tb_demux_1_4_stream;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [2:0]       occupancy;

  int n_checks;
  int n_fail;

  demux_1_4_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .occupancy (occupancy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and let registered outputs settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sender rule: a stalled offer must keep in_sel/in_data until accepted.
  logic             held_r;
  logic [1:0]       held_sel_r;
  logic [WIDTH-1:0] held_data_r;
  always @(posedge clk) begin
    if (held_r && in_valid) begin
      check_eq("hold_sel", {30'd0, in_sel}, {30'd0, held_sel_r});
      check_eq("hold_data", {28'd0, in_data}, {28'd0, held_data_r});
    end
    held_r      <= rst_n & in_valid & ~in_ready;
    held_sel_r  <= in_sel;
    held_data_r <= in_data;
  end

  initial begin
    logic [3:0] vals [4];
    n_checks  = 0;
    n_fail    = 0;
    held_r    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_sel    = 2'd0;
    out_ready = 4'b0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset state, no traffic.
    check_eq("rst_valid", {28'd0, out_valid}, 32'h0);
    check_eq("rst_occ", {29'd0, occupancy}, 32'h0);
    check_eq("rst_ready", {31'd0, in_ready}, 32'h1);
    check_eq("rst_data0", {28'd0, out_data0}, 32'h0);
    check_eq("rst_data3", {28'd0, out_data3}, 32'h0);

    // a,b,c,d to lanes 0..3 with all consumers ready: the previous lane
    // drains on the same edge the next one loads.
    vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC; vals[3] = 4'hD;
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      in_data  = vals[i];
      #1;
      check_eq("fan_ready", {31'd0, in_ready}, 32'h1);
      step();
      check_eq("fan_valid", {28'd0, out_valid}, 32'h1 << i);
      check_eq("fan_occ", {29'd0, occupancy}, 32'h1);
    end
    check_eq("fan_d0", {28'd0, out_data0}, 32'hA);
    check_eq("fan_d1", {28'd0, out_data1}, 32'hB);
    check_eq("fan_d2", {28'd0, out_data2}, 32'hC);
    check_eq("fan_d3", {28'd0, out_data3}, 32'hD);
    in_valid = 1'b0;
    step();
    check_eq("fan_empty", {28'd0, out_valid}, 32'h0);
    check_eq("fan_occ0", {29'd0, occupancy}, 32'h0);

    // Stall on lane 2, then release: 3 loads on the edge where 7 drains.
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 4'h7;
    #1;
    check_eq("st_ready1", {31'd0, in_ready}, 32'h1);
    step();
    check_eq("st_valid1", {28'd0, out_valid}, 32'h4);
    check_eq("st_d2a", {28'd0, out_data2}, 32'h7);
    in_data = 4'h3;
    #1;
    check_eq("st_ready2", {31'd0, in_ready}, 32'h0);
    step();
    check_eq("st_d2hold", {28'd0, out_data2}, 32'h7);
    check_eq("st_occ", {29'd0, occupancy}, 32'h1);
    out_ready = 4'b0100;
    #1;
    check_eq("st_ready3", {31'd0, in_ready}, 32'h1);
    step();
    check_eq("st_d2b", {28'd0, out_data2}, 32'h3);
    check_eq("st_valid2", {28'd0, out_valid}, 32'h4);
    check_eq("st_occ2", {29'd0, occupancy}, 32'h1);
    in_valid = 1'b0;
    step();
    check_eq("st_drain", {28'd0, out_valid}, 32'h0);
    check_eq("st_occ0", {29'd0, occupancy}, 32'h0);
    out_ready = 4'b0000;

    // Lane 1 stalled full does not block a write to lane 0.
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 4'h9;
    step();
    in_sel  = 2'd0;
    in_data = 4'h5;
    #1;
    check_eq("iso_ready", {31'd0, in_ready}, 32'h1);
    step();
    check_eq("iso_d0", {28'd0, out_data0}, 32'h5);
    check_eq("iso_d1", {28'd0, out_data1}, 32'h9);
    check_eq("iso_valid", {28'd0, out_valid}, 32'h3);
    check_eq("iso_occ", {29'd0, occupancy}, 32'h2);

    // Fill lanes 2 and 3: all four full, every selection blocked.
    in_sel  = 2'd2;
    in_data = 4'h6;
    step();
    in_sel  = 2'd3;
    in_data = 4'h8;
    step();
    in_valid = 1'b0;
    check_eq("full_valid", {28'd0, out_valid}, 32'hF);
    check_eq("full_occ", {29'd0, occupancy}, 32'h4);
    check_eq("full_d3", {28'd0, out_data3}, 32'h8);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check_eq("full_ready", {31'd0, in_ready}, 32'h0);
    end

    // Reset asserted mid-cycle clears all slots without waiting for a clock.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", {28'd0, out_valid}, 32'h0);
    check_eq("mrst_occ", {29'd0, occupancy}, 32'h0);
    check_eq("mrst_d2", {28'd0, out_data2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("mrst_after", {28'd0, out_valid}, 32'h0);

    // Back-to-back stream into lane 3: one transfer per cycle, in order.
    out_ready = 4'b1000;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    for (int k = 0; k < 8; k++) begin
      in_data = 4'(k + 1);
      #1;
      check_eq("strm_ready", {31'd0, in_ready}, 32'h1);
      step();
      check_eq("strm_valid", {28'd0, out_valid}, 32'h8);
      check_eq("strm_d3", {28'd0, out_data3}, 32'(k + 1));
      check_eq("strm_occ", {29'd0, occupancy}, 32'h1);
    end
    in_valid = 1'b0;
    step();
    check_eq("strm_end", {28'd0, out_valid}, 32'h0);
    check_eq("strm_occ0", {29'd0, occupancy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
